// File: rtl/fft_cadd_arbiter_if.sv
// Request/result bundle shared by the FFT complex-adder arbiter and its clients.
// Samples are packed {data_r, data_i}, each DW bits wide.
`ifndef FFT_DATA_WIDTH
`define FFT_DATA_WIDTH 16
`endif

interface fft_cadd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = `FFT_DATA_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  // Handshake: a transfer happens on a cycle where valid & ready are both 1;
  // valid must not wait for ready, and ready may depend on valid.
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][2*DW-1:0]   req_opa;
  logic [NUM_REQ-1:0][2*DW-1:0]   req_opb;
  logic                           res_valid;
  logic                           res_ready;
  logic [2*DW-1:0]                res_data;
  logic [ID_W-1:0]                res_id;
  logic                           busy;

  modport master (
    output req_valid, req_opa, req_opb, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req_valid, req_opa, req_opb, res_ready,
    output req_ready, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/fft_cadd_arbiter.sv
// Round-robin arbiter sharing one 2-cycle complex adder, with a credit-guarded result FIFO.
// Optional grant statistics are enabled by defining FFT_CADD_ARB_STATS_EN.
`ifndef FFT_DATA_WIDTH
`define FFT_DATA_WIDTH 16
`endif

module fft_cadd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int RES_DEPTH = 4,
  parameter int ID_W      = $clog2(NUM_REQ),
  parameter int DW        = `FFT_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  fft_cadd_arbiter_if.slave bus
`ifdef FFT_CADD_ARB_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [NUM_REQ-1:0][15:0] stat_grant_cnt
`endif
);
  localparam int SW = 2 * DW;
  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  logic [ID_W-1:0]    r_rr_ptr;
  logic [CW-1:0]      r_credits;
  logic [CW-1:0]      r_count;
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [1:0]         r_tag_vld;
  logic [ID_W-1:0]    r_tag_id [2];
  logic [SW-1:0]      r_sum1;
  logic [SW-1:0]      r_sum2;
  logic [SW-1:0]      r_mem    [RES_DEPTH];
  logic [ID_W-1:0]    r_id_mem [RES_DEPTH];

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gnt_id;
  logic               w_acc;
  logic               w_pop;
  logic               w_wr;
  logic [SW-1:0]      w_opa;
  logic [SW-1:0]      w_opb;

  function automatic logic [SW-1:0] cadd(input logic [SW-1:0] a, input logic [SW-1:0] b);
    cadd = {a[SW-1:DW] + b[SW-1:DW], a[DW-1:0] + b[DW-1:0]};
  endfunction

  // Search starts one past the last winner; k == NUM_REQ lands back on it.
  always_comb begin : p_grant
    int tmp;
    logic [ID_W-1:0] idx;
    w_grant  = '0;
    w_gnt_id = '0;
    w_acc    = 1'b0;
    tmp      = 0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      tmp = int'(r_rr_ptr) + k;
      if (tmp >= NUM_REQ) tmp = tmp - NUM_REQ;
      idx = ID_W'(tmp);
      if (!w_acc && !rst && (r_credits != '0) && bus.req_valid[idx]) begin
        w_acc         = 1'b1;
        w_grant[idx]  = 1'b1;
        w_gnt_id      = idx;
      end
    end
  end

  assign w_opa = bus.req_opa[w_gnt_id];
  assign w_opb = bus.req_opb[w_gnt_id];
  assign w_pop = (r_count != '0) && bus.res_ready;
  assign w_wr  = r_tag_vld[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= ID_W'(NUM_REQ - 1);
      r_credits   <= CW'(RES_DEPTH);
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_tag_vld   <= '0;
      r_tag_id[0] <= '0;
      r_tag_id[1] <= '0;
      r_sum1      <= '0;
      r_sum2      <= '0;
    end else begin
      if (w_acc) r_rr_ptr <= w_gnt_id;
      r_credits   <= r_credits - CW'(w_acc) + CW'(w_pop);
      r_tag_vld   <= {r_tag_vld[0], w_acc};
      r_tag_id[0] <= w_gnt_id;
      r_tag_id[1] <= r_tag_id[0];
      r_sum1      <= cadd(w_opa, w_opb);
      r_sum2      <= r_sum1;
      if (w_wr) r_wr_ptr <= (r_wr_ptr == PW'(RES_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= (r_rd_ptr == PW'(RES_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      r_count     <= r_count + CW'(w_wr) - CW'(w_pop);
    end
  end

  // Storage needs no reset: the read side is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr]    <= r_sum2;
      r_id_mem[r_wr_ptr] <= r_tag_id[1];
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.res_valid = (r_count != '0);
  assign bus.res_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign bus.res_id    = (r_count != '0) ? r_id_mem[r_rd_ptr] : '0;
  assign bus.busy      = (|r_tag_vld) || (r_count != '0);

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst)
                    !(w_wr && !w_pop && (r_count == CW'(RES_DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
                    !(w_acc && (r_credits == '0)));
  a_credit_range: assert property (@(posedge clk) disable iff (rst)
                    (r_credits <= CW'(RES_DEPTH)));

`ifdef FFT_CADD_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] r_stat_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_cnt <= '0;
    end else if (stat_clr) begin
      r_stat_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i] && (r_stat_cnt[i] != 16'hFFFF)) r_stat_cnt[i] <= r_stat_cnt[i] + 16'd1;
      end
    end
  end

  assign stat_grant_cnt = r_stat_cnt;
`endif
endmodule

// File: tb/tb_fft_cadd_arbiter.sv
// Directed bench for fft_cadd_arbiter: scoreboard of issued ops checked against popped results.
// Grant statistics are exercised when FFT_CADD_ARB_STATS_EN is defined.
module tb_fft_cadd_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int RES_DEPTH = 4;
  localparam int DW        = 16;
  localparam int SW        = 2 * DW;
  localparam int ID_W      = 2;

  logic clk = 1'b0;
  logic rst;

  fft_cadd_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW), .ID_W(ID_W)) bus ();

`ifdef FFT_CADD_ARB_STATS_EN
  logic                     stat_clr;
  logic [NUM_REQ-1:0][15:0] stat_grant_cnt;
`endif

  fft_cadd_arbiter #(.NUM_REQ(NUM_REQ), .RES_DEPTH(RES_DEPTH), .ID_W(ID_W), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FFT_CADD_ARB_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_grant_cnt (stat_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ID_W+SW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] model_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [DW-1:0] re, im;
    re = a[SW-1:DW] + b[SW-1:DW];
    im = a[DW-1:0] + b[DW-1:0];
    return {re, im};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_opa[i] = $urandom();
      bus.req_opb[i] = $urandom();
    end
  endtask

  // Scoreboard: push on accept, pop-and-compare on result transfer.
  always @(negedge clk) begin
    if (!rst) begin
      chk("grant_onehot", 64'($countones(bus.req_ready) <= 1), 64'(1));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i])
          exp_q.push_back({ID_W'(i), model_add(bus.req_opa[i], bus.req_opb[i])});
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_result", 64'(1), 64'(0));
        end else begin
          logic [ID_W+SW-1:0] e;
          e = exp_q.pop_front();
          chk("res_data", 64'(bus.res_data), 64'(e[SW-1:0]));
          chk("res_id", 64'(bus.res_id), 64'(e[ID_W+SW-1:SW]));
        end
      end
    end
  end

  initial begin : main
    int n_acc;
    int exp_id;
    int ghosts;
    logic [NUM_REQ-1:0] one_hot;

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_opa   = '0;
    bus.req_opb   = '0;
    bus.res_ready = 1'b0;
`ifdef FFT_CADD_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    // Reset state, with requests pending to show ready stays low.
    #2;
    bus.req_valid = '1;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
    chk("rst_res_data", 64'(bus.res_data), 64'(0));
    chk("rst_res_id", 64'(bus.res_id), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_credits", 64'(dut.r_credits), 64'(RES_DEPTH));
    chk("rst_rr_ptr", 64'(dut.r_rr_ptr), 64'(NUM_REQ - 1));
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single op from requester 0: (1,2)+(3,4), result visible at T+3.
    tick();
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_opa[0] = 32'h0001_0002;
    bus.req_opb[0] = 32'h0003_0004;
    at_neg();
    chk("single_grant", 64'(bus.req_ready), 64'(4'b0001));
    tick();
    bus.req_valid = '0;
    at_neg();
    chk("single_t1_valid", 64'(bus.res_valid), 64'(0));
    chk("single_t1_busy", 64'(bus.busy), 64'(1));
    tick();
    at_neg();
    chk("single_t2_valid", 64'(bus.res_valid), 64'(0));
    tick();
    at_neg();
    chk("single_t3_valid", 64'(bus.res_valid), 64'(1));
    chk("single_t3_data", 64'(bus.res_data), 64'(32'h0004_0006));
    chk("single_t3_id", 64'(bus.res_id), 64'(0));
    tick();
    at_neg();
    chk("single_t4_busy", 64'(bus.busy), 64'(0));
    chk("single_t4_valid", 64'(bus.res_valid), 64'(0));

    // All requesters valid: strict rotation starting after requester 0.
    exp_id = 1;
    for (int c = 0; c < 12; c++) begin
      tick();
      bus.req_valid = '1;
      rand_ops();
      at_neg();
      one_hot = 4'b0001 << exp_id;
      chk("rr_order", 64'(bus.req_ready), 64'(one_hot));
      exp_id = (exp_id + 1) % NUM_REQ;
    end
    tick();
    bus.req_valid = '0;
    repeat (5) tick();
    chk("rr_drain_busy", 64'(bus.busy), 64'(0));
    chk("rr_drain_queue", 64'(exp_q.size()), 64'(0));

    // Backpressure: exactly RES_DEPTH accepts, then none.
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b0010;
    rand_ops();
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      at_neg();
      if (bus.req_valid[1] && bus.req_ready[1]) n_acc++;
      tick();
      rand_ops();
    end
    chk("bp_accepts", 64'(n_acc), 64'(RES_DEPTH));
    at_neg();
    chk("bp_ready_low", 64'(bus.req_ready), 64'(0));
    chk("bp_credits_zero", 64'(dut.r_credits), 64'(0));
    chk("bp_full", 64'(dut.r_count), 64'(RES_DEPTH));
    tick();
    rand_ops();

    // Release: one accept per pop after the first pop frees a credit.
    bus.res_ready = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      at_neg();
      if (bus.req_valid[1] && bus.req_ready[1]) n_acc++;
      if (c >= 1) chk("bp_credits_steady", 64'(dut.r_credits), 64'(1));
      tick();
      rand_ops();
    end
    chk("bp_release_accepts", 64'(n_acc), 64'(9));
    bus.req_valid = '0;
    repeat (6) tick();
    chk("bp_drain_queue", 64'(exp_q.size()), 64'(0));
    chk("bp_drain_credits", 64'(dut.r_credits), 64'(RES_DEPTH));

    // Reset with two ops in flight and two queued.
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b0100;
    rand_ops();
    for (int c = 0; c < 4; c++) begin
      at_neg();
      chk("mr_fill_grant", 64'(bus.req_ready), 64'(4'b0100));
      tick();
      rand_ops();
    end
    bus.req_valid = '0;
    chk("mr_queued", 64'(dut.r_count), 64'(2));
    chk("mr_in_flight", 64'(dut.r_tag_vld), 64'(2'b11));
    rst = 1'b1;
    #1;
    chk("mr_res_valid", 64'(bus.res_valid), 64'(0));
    chk("mr_res_data", 64'(bus.res_data), 64'(0));
    chk("mr_busy", 64'(bus.busy), 64'(0));
    chk("mr_credits", 64'(dut.r_credits), 64'(RES_DEPTH));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.res_ready = 1'b1;
    ghosts = 0;
    for (int c = 0; c < 10; c++) begin
      at_neg();
      if (bus.res_valid) ghosts++;
      tick();
    end
    chk("mr_no_ghosts", 64'(ghosts), 64'(0));
    chk("mr_post_credits", 64'(dut.r_credits), 64'(RES_DEPTH));
    chk("mr_post_busy", 64'(bus.busy), 64'(0));

`ifdef FFT_CADD_ARB_STATS_EN
    // Five grants to requester 2, then clear colliding with a sixth grant.
    chk("stat_reset", 64'(stat_grant_cnt[2]), 64'(0));
    bus.req_valid = 4'b0100;
    rand_ops();
    for (int c = 0; c < 5; c++) begin
      at_neg();
      tick();
      rand_ops();
    end
    bus.req_valid = '0;
    at_neg();
    chk("stat_count5", 64'(stat_grant_cnt[2]), 64'(5));
    chk("stat_other", 64'(stat_grant_cnt[1]), 64'(0));
    tick();
    bus.req_valid = 4'b0100;
    stat_clr = 1'b1;
    at_neg();
    chk("stat_clr_grant", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    bus.req_valid = '0;
    stat_clr = 1'b0;
    at_neg();
    chk("stat_cleared", 64'(stat_grant_cnt[2]), 64'(0));
    repeat (6) tick();
`endif

    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("final_busy", 64'(bus.busy), 64'(0));
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
